// File: rtl/burst_readback_checker.sv
// Reads captured burst words back from the capture RAM, unpacks them slot by slot
// and compares each sample against a golden stream, keeping error count and first-failure location.
module burst_readback_checker #(
  parameter int no_of_digits  = 8,
  parameter int radix_bits    = 3,
  parameter int burst_index   = 8,
  parameter int address_width = 14,
  parameter int ram_latency   = 2
) (
  input  logic                                                  ctrl_clk,
  input  logic                                                  reset_n,
  input  logic                                                  start,
  input  logic [address_width:0]                                num_words,
  output logic [address_width-1:0]                              ram_addr,
  output logic                                                  ram_rd_en,
  input  logic [(no_of_digits+1)*radix_bits*burst_index-1:0]    mem_read,
  input  logic [(no_of_digits+1)*radix_bits-1:0]                exp_sample,
  input  logic                                                  exp_valid,
  output logic                                                  exp_ready,
  output logic                                                  busy,
  output logic                                                  done,
  output logic [31:0]                                           error_count,
  output logic                                                  error_flag,
  output logic [address_width-1:0]                              first_err_addr,
  output logic [$clog2(burst_index)-1:0]                        first_err_slot
);

  localparam int W      = (no_of_digits + 1) * radix_bits;
  localparam int WORD_W = W * burst_index;
  localparam int SLOT_W = $clog2(burst_index);
  localparam int LAT_W  = $clog2(ram_latency + 1);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, CHECK, FINISH} state_t;

  state_t                   state;
  logic [address_width:0]   num_lat;
  logic [LAT_W-1:0]         wait_cnt;
  logic [SLOT_W-1:0]        slot;
  logic [WORD_W-1:0]        unpack;

  logic                     load_word;
  logic                     consume;
  logic                     mismatch;
  logic                     last_slot;
  logic                     last_addr;

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  // The unpack register shifts right after every compare, so the current slot is always at the bottom.
  assign load_word = (state == WAIT) && (wait_cnt == LAT_W'(ram_latency - 1));
  assign consume   = (state == CHECK) && exp_valid;
  assign mismatch  = (unpack[W-1:0] != exp_sample);
  assign last_slot = (slot == SLOT_W'(burst_index - 1));
  assign last_addr = ({1'b0, ram_addr} == (num_lat - (address_width+1)'(1)));

  always_ff @(posedge ctrl_clk) begin
    if (load_word) begin
      unpack <= mem_read;
    end else if (consume) begin
      unpack <= unpack >> W;
    end
  end

  always_ff @(posedge ctrl_clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      ram_addr       <= '0;
      ram_rd_en      <= 1'b0;
      exp_ready      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error_count    <= '0;
      error_flag     <= 1'b0;
      first_err_addr <= '0;
      first_err_slot <= '0;
      num_lat        <= '0;
      wait_cnt       <= '0;
      slot           <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy           <= 1'b1;
            num_lat        <= num_words;
            ram_addr       <= '0;
            error_count    <= '0;
            error_flag     <= 1'b0;
            first_err_addr <= '0;
            first_err_slot <= '0;
            if (num_words != '0) begin
              ram_rd_en <= 1'b1;
              state     <= FETCH;
            end else begin
              state <= FINISH;
            end
          end
        end

        FETCH: begin
          ram_rd_en <= 1'b0;
          wait_cnt  <= '0;
          state     <= WAIT;
        end

        WAIT: begin
          if (load_word) begin
            slot      <= '0;
            exp_ready <= 1'b1;
            state     <= CHECK;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        CHECK: begin
          if (exp_valid) begin
            if (mismatch) begin
              error_count <= sat_inc(error_count);
              error_flag  <= 1'b1;
              if (!error_flag) begin
                first_err_addr <= ram_addr;
                first_err_slot <= slot;
              end
            end
            if (last_slot) begin
              slot      <= '0;
              exp_ready <= 1'b0;
              if (last_addr) begin
                done  <= 1'b1;
                state <= FINISH;
              end else begin
                ram_addr  <= ram_addr + 1'b1;
                ram_rd_en <= 1'b1;
                state     <= FETCH;
              end
            end else begin
              slot <= slot + 1'b1;
            end
          end
        end

        FINISH: begin
          // An empty run arrives here with done low and raises it one cycle later.
          if (done) begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            done <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
